key_matrix_scanner: RTL

KEY_MATRIX_SCANNER -- requirements
Module: key_matrix_scanner

---
 rtl/key_matrix_scanner.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/key_matrix_scanner.sv
// Key matrix scanner for a 4-row x 3-column keypad.
// Drives one column at a time, samples the rows on each scan tick, debounces
// both press and release, and reports one registered key code per physical
// press with a single-cycle key_valid pulse when the code first appears.
module key_matrix_scanner #(
    parameter int SCAN_DIV = 4,   // clk cycles per scan tick (2..65535)
    parameter int DEB_CNT  = 8    // matching ticks to accept press/release (1..255)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_row,
    output logic [2:0] key_col,
    output logic [3:0] num,
    output logic       key_valid
);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
    localparam logic [7:0]  DEB_LAST = 8'(DEB_CNT);
    localparam logic [3:0]  CODE_SN  = 4'd0;
    localparam logic [3:0]  CODE_SA  = 4'd1;
    localparam logic [3:0]  CODE_SS  = 4'd2;
    localparam logic [3:0]  CODE_D0  = 4'd3;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] div_cnt;
    logic        tick;
    logic [7:0]  deb_cnt;
    logic [7:0]  deb_nxt;
    logic [7:0]  deb_inc;
    logic [1:0]  cand_row;
    logic [1:0]  cand_row_nxt;
    logic [1:0]  cand_col;
    logic [1:0]  cand_col_nxt;
    logic [2:0]  key_col_nxt;
    logic [3:0]  num_nxt;
    logic        key_valid_nxt;
    logic        row_valid;
    logic [1:0]  row_idx;

    // Index of the highest set bit of the row sample; only meaningful when
    // exactly one bit is set.
    function automatic logic [1:0] row_index(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (rows[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    // Index of the driven column from the one-hot column drive.
    function automatic logic [1:0] col_index(input logic [2:0] cols);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 3; i++) begin
            if (cols[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    // Next column in the left-to-right rotation 001 -> 010 -> 100 -> 001.
    function automatic logic [2:0] rotate_col(input logic [2:0] cols);
        return {cols[1:0], cols[2]};
    endfunction

    // Keypad legend to key code. Rows 0..2 hold digits 1..9 in reading
    // order; row 3 holds *, 0, #.
    function automatic logic [3:0] key_code(input logic [1:0] row,
                                            input logic [1:0] col);
        logic [3:0] code;
        if (row == 2'd3) begin
            case (col)
                2'd0:    code = CODE_SA;
                2'd1:    code = CODE_D0;
                default: code = CODE_SS;
            endcase
        end else begin
            // digit = row*3 + col + 1, code = digit + 3
            code = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd4;
        end
        return code;
    endfunction

    assign tick      = (div_cnt == DIV_LAST);
    assign row_valid = (key_row != 4'd0) && ((key_row & (key_row - 4'd1)) == 4'd0);
    assign row_idx   = row_index(key_row);
    assign deb_inc   = deb_cnt + 8'd1;

    // Free-running scan divider; tick marks its terminal count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

    // State and registered outputs; all decisions are made in the
    // next-state logic below and only take effect on tick cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SCAN;
            key_col   <= 3'b001;
            num       <= CODE_SN;
            key_valid <= 1'b0;
            deb_cnt   <= '0;
            cand_row  <= '0;
            cand_col  <= '0;
        end else begin
            state     <= state_nxt;
            key_col   <= key_col_nxt;
            num       <= num_nxt;
            key_valid <= key_valid_nxt;
            deb_cnt   <= deb_nxt;
            cand_row  <= cand_row_nxt;
            cand_col  <= cand_col_nxt;
        end
    end

    // Next-state logic: scan, debounce the press, hold, debounce the release.
    // A multi-row sample is treated exactly like an empty one.
    always_comb begin
        state_nxt     = state;
        key_col_nxt   = key_col;
        num_nxt       = num;
        key_valid_nxt = 1'b0;
        deb_nxt       = deb_cnt;
        cand_row_nxt  = cand_row;
        cand_col_nxt  = cand_col;

        if (tick) begin
            case (state)
                SCAN: begin
                    if (row_valid) begin
                        cand_row_nxt = row_idx;
                        cand_col_nxt = col_index(key_col);
                        deb_nxt      = '0;
                        state_nxt    = DEBOUNCE;
                    end else begin
                        key_col_nxt = rotate_col(key_col);
                    end
                end

                DEBOUNCE: begin
                    if (row_valid && (row_idx == cand_row)) begin
                        deb_nxt = deb_inc;
                        if (deb_inc == DEB_LAST) begin
                            state_nxt     = PRESSED;
                            num_nxt       = key_code(cand_row, cand_col);
                            key_valid_nxt = 1'b1;
                        end
                    end else begin
                        // Bounce: give up, keep the column, keep scanning.
                        state_nxt = SCAN;
                    end
                end

                PRESSED: begin
                    // Another single row in this column is ignored; only an
                    // empty sample starts the release debounce.
                    if (!row_valid) begin
                        deb_nxt   = '0;
                        state_nxt = RELEASE;
                    end
                end

                RELEASE: begin
                    if (!row_valid) begin
                        deb_nxt = deb_inc;
                        if (deb_inc == DEB_LAST) begin
                            num_nxt     = CODE_SN;
                            state_nxt   = SCAN;
                            key_col_nxt = rotate_col(key_col);
                        end
                    end else begin
                        // Dropout shorter than the debounce time: still held.
                        state_nxt = PRESSED;
                    end
                end

                default: begin
                    state_nxt = SCAN;
                end
            endcase
        end
    end

endmodule
